instr_fetch: RTL and testbench

Instruction fetch unit for the RISC-V core. Owns the program counter, fetches words from instruction memory over a request/grant/response handshake, and presents one instruction at a time to decode with a valid/ready handshake. When decode accepts an instruction, it returns the `PCSrc` selection produced by the control unit, and the fetch unit computes the next PC from it. It is the producer of `Instr` and the consumer of `PCSrc`.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/instr_fetch_if.sv | 45 ++++
 rtl/instr_fetch_next_pc_sel.sv | 46 ++++
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V front end: data-path width, PCSrc
// encodings, the canonical NOP, the decode payload struct, the fetch FSM
// state enum and a small PC increment helper.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (adds the ERR fetch state).
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Instruction word and its address, as handed to decode
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
`ifdef FETCH_ALIGN_CHECK_EN
        , ST_ERR
`endif
    } fetch_state_e;

    // Sequential successor; wraps modulo 2^32
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the instruction-memory request/grant/response bus and the
// decode valid/ready bus of the fetch unit.
//   master : the fetch unit (drives imem_req/imem_addr and the instr_* outputs)
//   slave  : memory + decode side (drives grant, read data, ready, PCSrc,
//            pc_target, alu_result)
// -----------------------------------------------------------------------------
interface instr_fetch_if;
    import riscv_pkg::*;

    // instruction memory side
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    // decode side
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] instr_pc_plus4;
    logic            instr_ready;
    logic [1:0]      PCSrc;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] alu_result;

    logic            fetch_misaligned;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc, instr_pc_plus4, fetch_misaligned,
        input  instr_ready, PCSrc, pc_target, alu_result
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc, instr_pc_plus4, fetch_misaligned,
        output instr_ready, PCSrc, pc_target, alu_result
    );

endinterface

// File: rtl/instr_fetch_next_pc_sel.sv
// -----------------------------------------------------------------------------
// next_pc_sel
// Combinational next-PC mux over PC+4, pc_target and alu_result.
//   i_pc           : current fetch PC
//   i_pcsrc        : PCSrc select (11 behaves as PC+4)
//   i_pc_target    : branch / JAL target
//   i_alu_result   : JALR target
//   o_next_pc_c    : selected next PC
//   o_misaligned_c : selected target not word aligned (only with
//                    FETCH_ALIGN_CHECK_EN; otherwise the low bits are cleared)
// -----------------------------------------------------------------------------
module next_pc_sel
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] i_pc,
    input  logic [1:0]      i_pcsrc,
    input  logic [XLEN-1:0] i_pc_target,
    input  logic [XLEN-1:0] i_alu_result,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic            o_misaligned_c,
`endif
    output logic [XLEN-1:0] o_next_pc_c
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] w_sel_pc;

    // PCSrc mux; the reserved encoding falls back to sequential
    always_comb begin
        w_sel_pc = pc_plus4(i_pc);
        case (i_pcsrc)
            PCSRC_TARGET: w_sel_pc = i_pc_target;
            PCSRC_JALR:   w_sel_pc = i_alu_result;
            default:      w_sel_pc = pc_plus4(i_pc);
        endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign o_misaligned_c = (w_sel_pc[1:0] != 2'b00);
    assign o_next_pc_c    = w_sel_pc;
`else
    assign o_next_pc_c    = w_sel_pc & ALIGN_MASK;
`endif

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit: owns the PC, fetches one word at a time over the
// imem request/grant/response bus and holds it for decode until accepted,
// then advances the PC according to PCSrc.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_if.master (imem bus + decode bus, see interface)
//   RESET_PC   : first fetch address after reset (word aligned)
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- a misaligned next PC traps
// into a sticky ERR state with fetch_misaligned set; left only by reset.
// All outputs are registered.
// -----------------------------------------------------------------------------
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_imem_req;
    logic            r_instr_valid;
    fetch_pkt_t      r_pkt;
    logic [XLEN-1:0] r_pc_plus4;
    logic [XLEN-1:0] w_next_pc_c;
`ifdef FETCH_ALIGN_CHECK_EN
    logic            r_misaligned;
    logic            w_misaligned_c;
`endif

    next_pc_sel u_next_pc_sel (
        .i_pc           (r_pc),
        .i_pcsrc        (bus.PCSrc),
        .i_pc_target    (bus.pc_target),
        .i_alu_result   (bus.alu_result),
`ifdef FETCH_ALIGN_CHECK_EN
        .o_misaligned_c (w_misaligned_c),
`endif
        .o_next_pc_c    (w_next_pc_c)
    );

    // Fetch FSM with registered outputs; inputs outside their state are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_pkt         <= '{instr: NOP_INSTR, pc: RESET_PC};
            r_pc_plus4    <= pc_plus4(RESET_PC);
`ifdef FETCH_ALIGN_CHECK_EN
            r_misaligned  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_imem_req <= 1'b1;
                    r_state    <= ST_REQ;
                end
                ST_REQ: begin
                    // address is r_pc, which only moves on accept
                    if (bus.imem_gnt) begin
                        r_imem_req <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        r_pkt         <= '{instr: bus.imem_rdata, pc: r_pc};
                        r_pc_plus4    <= pc_plus4(r_pc);
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.instr_ready) begin
                        r_instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                        if (w_misaligned_c) begin
                            r_misaligned <= 1'b1;
                            r_state      <= ST_ERR;
                        end else begin
                            r_pc       <= w_next_pc_c;
                            r_imem_req <= 1'b1;
                            r_state    <= ST_REQ;
                        end
`else
                        r_pc       <= w_next_pc_c;
                        r_imem_req <= 1'b1;
                        r_state    <= ST_REQ;
`endif
                    end
                end
`ifdef FETCH_ALIGN_CHECK_EN
                ST_ERR: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
`endif
                default: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req       = r_imem_req;
    assign bus.imem_addr      = r_pc;
    assign bus.instr_valid    = r_instr_valid;
    assign bus.instr          = r_pkt.instr;
    assign bus.instr_pc       = r_pkt.pc;
    assign bus.instr_pc_plus4 = r_pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.fetch_misaligned = r_misaligned;
`else
    assign bus.fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch: acts as instruction memory and decode.
// Each granted fetch pushes the expected {instr, pc} to a scoreboard queue,
// popped and compared when instr_valid appears. The bench keeps its own
// model of the fetch PC to check every next imem_addr.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_pkt_t  sb_q[$];
    logic [31:0] exp_pc;

    // Memory contents: word at address 0 is 0x00500093 (addi x1,x0,5)
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 + (a << 8);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_req"},    32'(bus.imem_req), 32'd0);
        check_eq({tag, "_addr"},   bus.imem_addr, RESET_PC);
        check_eq({tag, "_valid"},  32'(bus.instr_valid), 32'd0);
        check_eq({tag, "_instr"},  bus.instr, 32'h0000_0013);
        check_eq({tag, "_pc"},     bus.instr_pc, RESET_PC);
        check_eq({tag, "_pc4"},    bus.instr_pc_plus4, RESET_PC + 32'd4);
        check_eq({tag, "_misal"},  32'(bus.fetch_misaligned), 32'd0);
    endtask

    // Serve one fetch at exp_pc with optional grant / response delays
    task automatic fetch(input int gnt_dly, input int rv_dly, output int unsigned t_valid);
        int          n;
        int unsigned t_gnt;
        fetch_pkt_t  exp;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_seen", 32'(bus.imem_req), 32'd1);
        check_eq("req_addr", bus.imem_addr, exp_pc);
        for (int i = 0; i < gnt_dly; i++) begin
            @(negedge clk);
            check_eq("addr_stable", bus.imem_addr, exp_pc);
            check_eq("req_held", 32'(bus.imem_req), 32'd1);
        end
        bus.imem_gnt = 1'b1;
        t_gnt = cyc;
        sb_q.push_back('{instr: mem_word(exp_pc), pc: exp_pc});
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        check_eq("req_drop", 32'(bus.imem_req), 32'd0);
        // In WAIT: stray grant and ready must be ignored
        for (int i = 0; i < rv_dly; i++) begin
            bus.imem_gnt    = 1'b1;
            bus.instr_ready = 1'b1;
            @(negedge clk);
            check_eq("wait_valid", 32'(bus.instr_valid), 32'd0);
            check_eq("wait_req", 32'(bus.imem_req), 32'd0);
        end
        bus.imem_gnt    = 1'b0;
        bus.instr_ready = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(exp_pc);
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("valid_seen", 32'(bus.instr_valid), 32'd1);
        t_valid = cyc;
        if (rv_dly == 0) check_eq("valid_latency", t_valid - t_gnt, 32'd2);
        check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check_eq("instr", bus.instr, exp.instr);
            check_eq("instr_pc", bus.instr_pc, exp.pc);
            check_eq("instr_pc_plus4", bus.instr_pc_plus4, exp.pc + 32'd4);
        end
    endtask

    // Decode accepts after 'stall' cycles of backpressure
    task automatic accept(input logic [1:0] src, input logic [31:0] tgt,
                          input logic [31:0] alu, input int stall);
        logic [31:0] held_instr;
        logic [31:0] held_pc;
        logic [31:0] nxt;
        held_instr = bus.instr;
        held_pc    = bus.instr_pc;
        for (int i = 0; i < stall; i++) begin
            bus.instr_ready = 1'b0;
            bus.imem_rvalid = (i == 1);
            bus.imem_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            check_eq("stall_valid", 32'(bus.instr_valid), 32'd1);
            check_eq("stall_instr", bus.instr, held_instr);
            check_eq("stall_pc", bus.instr_pc, held_pc);
            check_eq("stall_noreq", 32'(bus.imem_req), 32'd0);
        end
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b1;
        bus.PCSrc       = src;
        bus.pc_target   = tgt;
        bus.alu_result  = alu;
        case (src)
            2'b01:   nxt = tgt;
            2'b10:   nxt = alu;
            default: nxt = exp_pc + 32'd4;
        endcase
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.PCSrc       = 2'b01;
        bus.pc_target   = 32'h5555_5554;
        bus.alu_result  = 32'hAAAA_AAA8;
        check_eq("accept_valid_drop", 32'(bus.instr_valid), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        if (nxt[1:0] != 2'b00) begin
            check_eq("misal_flag", 32'(bus.fetch_misaligned), 32'd1);
            check_eq("misal_noreq", 32'(bus.imem_req), 32'd0);
        end else begin
            exp_pc = nxt;
            check_eq("next_req", 32'(bus.imem_req), 32'd1);
            check_eq("next_addr", bus.imem_addr, exp_pc);
            check_eq("no_misal", 32'(bus.fetch_misaligned), 32'd0);
        end
`else
        exp_pc = nxt & 32'hFFFF_FFFC;
        check_eq("next_req", 32'(bus.imem_req), 32'd1);
        check_eq("next_addr", bus.imem_addr, exp_pc);
        check_eq("no_misal", 32'(bus.fetch_misaligned), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0;
        int unsigned t1;
        int unsigned t2;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        bus.PCSrc       = 2'b00;
        bus.pc_target   = 32'h0;
        bus.alu_result  = 32'h0;
        exp_pc          = RESET_PC;
        rst_n           = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("req_after_rst", 32'(bus.imem_req), 32'd1);

        // first fetch plus sequential run
        fetch(0, 0, t0);
        accept(2'b00, 32'h0, 32'h0, 0);
        fetch(0, 0, t1);
        accept(2'b00, 32'h0, 32'h0, 0);
        fetch(0, 0, t2);
        check_eq("seq_period", t2 - t1, 32'd3);

        // taken branch then JALR
        accept(2'b01, 32'h0000_0040, 32'h0, 0);
        fetch(0, 0, t0);
        accept(2'b10, 32'h0, 32'h0000_0100, 0);

        // grant and response backpressure, decode stall with stray rvalid
        fetch(3, 2, t0);
        accept(2'b00, 32'h0, 32'h0, 5);

        // reserved PCSrc behaves as PC+4
        fetch(0, 0, t0);
        accept(2'b11, 32'h0000_0200, 32'h0000_0300, 0);

        // misaligned JALR target
        fetch(0, 0, t0);
        accept(2'b10, 32'h0, 32'h0000_0102, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            bus.imem_gnt = 1'b1;
            @(negedge clk);
            check_eq("err_sticky", 32'(bus.fetch_misaligned), 32'd1);
            check_eq("err_noreq", 32'(bus.imem_req), 32'd0);
            check_eq("err_novalid", 32'(bus.instr_valid), 32'd0);
        end
        bus.imem_gnt = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("err_rst");
        rst_n  = 1'b1;
        exp_pc = RESET_PC;
`endif
        fetch(0, 0, t0);

        // wrap-around: 0xFFFF_FFFC + 4 -> 0
        accept(2'b01, 32'hFFFF_FFFC, 32'h0, 0);
        fetch(0, 0, t0);
        accept(2'b00, 32'h0, 32'h0, 0);
        fetch(0, 0, t0);
        accept(2'b01, 32'h0000_0080, 32'h0, 0);

        // async reset while waiting for the response
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        check_eq("wait_addr", bus.imem_addr, 32'h0000_0080);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        sb_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = RESET_PC;
        fetch(0, 0, t0);
        accept(2'b00, 32'h0, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
